// File: rtl/paint_pkg.sv
// Shared types and constants for the paint/brush keyboard path.
// Holds the keycode type, the well-known HID codes used by the motion
// block, and the state type of the optional key-repeat gating FSM.
package paint_pkg;

  typedef logic [7:0] keycode_t;

  localparam keycode_t KEY_NONE    = 8'h00;
  localparam keycode_t KEY_W       = 8'h1A;
  localparam keycode_t KEY_A       = 8'h04;
  localparam keycode_t KEY_S       = 8'h16;
  localparam keycode_t KEY_D       = 8'h07;
  localparam keycode_t HID_ERR_MAX = 8'h03;

  // Step-mode gating states between the stack top and keycode.
  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_PRESS  = 2'd1,
    REP_DELAY  = 2'd2,
    REP_REPEAT = 2'd3
  } rep_state_t;

  // Codes 0x00..0x03 are empty slots or HID rollover/error markers.
  function automatic logic is_real_key(input keycode_t k);
    return k > HID_ERR_MAX;
  endfunction

endpackage

// File: rtl/keycode_sequencer_key_stack.sv
// Ordered held-key stack. Entry 0 is the oldest held key, the highest
// occupied entry is the most recently pressed key (the top). Unused
// entries are kept at KEY_NONE so membership tests need no count compare.
// On commit the stack drops keys missing from the report (compacting
// toward entry 0, order preserved) and then pushes keys that are new in
// the report in ascending slot order; keys that do not fit are dropped.
module key_stack
  import paint_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   commit,
  input  logic                   clear,
  input  logic [8*NUM_SLOTS-1:0] report_keys,
  output keycode_t               top,
  output keycode_t               top_next,
  output logic [CW-1:0]          count
);

  keycode_t      stk_q [NUM_SLOTS];
  keycode_t      stk_d [NUM_SLOTS];
  keycode_t      stk_step [NUM_SLOTS];
  logic [CW-1:0] cnt_q, cnt_d, cnt_step;
  keycode_t      top_q, top_d, top_step;

  keycode_t             slot_key [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] entry_kept;
  logic [NUM_SLOTS-1:0] slot_new;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_key[gi] = report_keys[8*gi +: 8];

      // An occupied stack entry survives only if the report still holds it.
      always_comb begin
        entry_kept[gi] = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
          if (stk_q[gi] != KEY_NONE && slot_key[j] == stk_q[gi]) begin
            entry_kept[gi] = 1'b1;
          end
        end
      end

      // A report slot is a new press if it is a real key not already held.
      always_comb begin
        slot_new[gi] = (slot_key[gi] != KEY_NONE);
        for (int j = 0; j < NUM_SLOTS; j++) begin
          if (stk_q[j] == slot_key[gi]) begin
            slot_new[gi] = 1'b0;
          end
        end
      end
    end
  endgenerate

  // Remove/compact then push, producing the candidate next stack and its top.
  always_comb begin : p_step
    int n;
    n = 0;
    for (int p = 0; p < NUM_SLOTS; p++) begin
      stk_step[p] = KEY_NONE;
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (entry_kept[i]) begin
        for (int p = 0; p < NUM_SLOTS; p++) begin
          if (p == n) stk_step[p] = stk_q[i];
        end
        n = n + 1;
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_new[s] && n < NUM_SLOTS) begin
        for (int p = 0; p < NUM_SLOTS; p++) begin
          if (p == n) stk_step[p] = slot_key[s];
        end
        n = n + 1;
      end
    end
    top_step = KEY_NONE;
    for (int p = 0; p < NUM_SLOTS; p++) begin
      if (p + 1 == n) top_step = stk_step[p];
    end
    cnt_step = CW'(n);
  end

  // Select between hold, forced clear and a committed update.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    top_d = top_q;
    if (clear) begin
      for (int p = 0; p < NUM_SLOTS; p++) begin
        stk_d[p] = KEY_NONE;
      end
      cnt_d = '0;
      top_d = KEY_NONE;
    end else if (commit) begin
      stk_d = stk_step;
      cnt_d = cnt_step;
      top_d = top_step;
    end
  end

  // Stack state registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      stk_q <= '{default: KEY_NONE};
      cnt_q <= '0;
      top_q <= KEY_NONE;
    end else begin
      stk_q <= stk_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
    end
  end

  assign top      = top_q;
  assign top_next = top_d;
  assign count    = cnt_q;

endmodule

// File: rtl/keycode_sequencer.sv
// Keyboard HID report -> single motion keycode, one step per video frame.
// Filters and debounces reports, keeps held keys in press order through
// key_stack, and force-releases everything if reports stop arriving.
// Optional build macro KEY_REPEAT_EN: gate keycode through a step-mode
// press/delay/repeat FSM instead of following the stack top as a level.
module keycode_sequencer
  import paint_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int STABLE_REPORTS = 2,
  parameter int TIMEOUT_FRAMES = 60,
  parameter int REPEAT_DELAY   = 15,
  parameter int REPEAT_RATE    = 4
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           report_valid,
  input  logic [8*NUM_SLOTS-1:0]         report_keys,
  output logic [7:0]                     keycode,
  output logic                           key_new,
  output logic [$clog2(NUM_SLOTS+1)-1:0] held_count,
  output logic                           timeout
);

  localparam int             CW     = $clog2(NUM_SLOTS + 1);
  localparam logic [3:0]     STAB_N = 4'(STABLE_REPORTS);
  localparam logic [9:0]     TO_N   = 10'(TIMEOUT_FRAMES);

  logic [8*NUM_SLOTS-1:0] filt_keys;
  logic [8*NUM_SLOTS-1:0] cand_q, cand_d;
  logic [3:0]             stab_q, stab_d;
  logic [9:0]             frame_q, frame_d;
  logic                   timeout_q, timeout_d;
  logic                   key_new_q, key_new_d;
  logic                   stack_commit;
  logic                   stack_clear;
  keycode_t               stack_top;
  keycode_t               stack_top_next;
  logic [CW-1:0]          stack_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_filter
      keycode_t raw_key;
      logic     dup;
      assign raw_key = report_keys[8*gi +: 8];

      // A code already present in a lower slot is a duplicate.
      always_comb begin
        dup = 1'b0;
        for (int j = 0; j < gi; j++) begin
          if (report_keys[8*j +: 8] == raw_key) dup = 1'b1;
        end
      end

      assign filt_keys[8*gi +: 8] = (is_real_key(raw_key) && !dup) ? raw_key : KEY_NONE;
    end
  endgenerate

  // Debounce, commit decision and stall timeout.
  always_comb begin
    cand_d       = cand_q;
    stab_d       = stab_q;
    frame_d      = frame_q;
    timeout_d    = timeout_q;
    stack_commit = 1'b0;
    stack_clear  = 1'b0;
    if (report_valid) begin
      // A report always wins over an expiring frame counter.
      frame_d   = '0;
      timeout_d = 1'b0;
      if (filt_keys != cand_q) begin
        cand_d       = filt_keys;
        stab_d       = 4'd1;
        stack_commit = (STAB_N == 4'd1);
      end else if (stab_q < STAB_N) begin
        stab_d       = stab_q + 4'd1;
        stack_commit = (stab_q + 4'd1 == STAB_N);
      end
    end else if (frame_q != TO_N) begin
      frame_d = frame_q + 10'd1;
      if (frame_d == TO_N) begin
        stack_clear = 1'b1;
        cand_d      = '0;
        stab_d      = '0;
        timeout_d   = 1'b1;
      end
    end
    // Pulse only on a change to a nonzero top, fallbacks included.
    key_new_d = (stack_top_next != stack_top) && (stack_top_next != KEY_NONE);
  end

  // Debounce, timeout and key_new registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cand_q    <= '0;
      stab_q    <= '0;
      frame_q   <= '0;
      timeout_q <= 1'b0;
      key_new_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      frame_q   <= frame_d;
      timeout_q <= timeout_d;
      key_new_q <= key_new_d;
    end
  end

  key_stack #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_key_stack (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .commit      (stack_commit),
    .clear       (stack_clear),
    .report_keys (cand_d),
    .top         (stack_top),
    .top_next    (stack_top_next),
    .count       (stack_count)
  );

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] DELAY_N = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_N  = 8'(REPEAT_RATE);

  rep_state_t rep_state_q;
  logic [7:0] rep_cnt_q;
  keycode_t   keycode_q;

  // Step-mode gating: one frame on press, silent delay, then periodic pulses.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rep_state_q <= REP_IDLE;
      rep_cnt_q   <= '0;
      keycode_q   <= KEY_NONE;
    end else if (stack_top_next == KEY_NONE) begin
      rep_state_q <= REP_IDLE;
      rep_cnt_q   <= '0;
      keycode_q   <= KEY_NONE;
    end else if (stack_top_next != stack_top) begin
      rep_state_q <= REP_PRESS;
      rep_cnt_q   <= '0;
      keycode_q   <= stack_top_next;
    end else begin
      unique case (rep_state_q)
        REP_PRESS: begin
          rep_state_q <= REP_DELAY;
          rep_cnt_q   <= 8'd1;
          keycode_q   <= KEY_NONE;
        end
        REP_DELAY: begin
          if (rep_cnt_q >= DELAY_N) begin
            rep_state_q <= REP_REPEAT;
            rep_cnt_q   <= 8'd1;
            keycode_q   <= stack_top_next;
          end else begin
            rep_cnt_q <= rep_cnt_q + 8'd1;
            keycode_q <= KEY_NONE;
          end
        end
        REP_REPEAT: begin
          if (rep_cnt_q >= RATE_N) begin
            rep_cnt_q <= 8'd1;
            keycode_q <= stack_top_next;
          end else begin
            rep_cnt_q <= rep_cnt_q + 8'd1;
            keycode_q <= KEY_NONE;
          end
        end
        default: begin
          rep_state_q <= REP_IDLE;
          rep_cnt_q   <= '0;
          keycode_q   <= KEY_NONE;
        end
      endcase
    end
  end

  assign keycode = keycode_q;
`else
  // Level mode: repeat timing parameters have no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{8'(REPEAT_DELAY), 8'(REPEAT_RATE)};

  assign keycode = stack_top;
`endif

  assign key_new    = key_new_q;
  assign held_count = stack_count;
  assign timeout    = timeout_q;

endmodule

// File: doc/keycode_sequencer.md
# keycode_sequencer

Turns raw multi-slot keyboard HID reports into the single 8-bit `keycode` that drives the brush/ball motion block. Runs on `frame_clk`, one step per video frame. Per frame it:
- debounces reports,
- tracks held keys in press order (most-recent-pressed wins, falls back to the still-held older key),
- releases everything if the report stream stalls.

## Interface
Parameters:
- `NUM_SLOTS`, 4: key slots per HID report.
- `STABLE_REPORTS`, 2: consecutive identical reports required to commit (range 1..15).
- `TIMEOUT_FRAMES`, 60: frames without `report_valid` before forced release (range 1..1023).
- `REPEAT_DELAY`, 15: frames of silence after first press (`KEY_REPEAT_EN` only).
- `REPEAT_RATE`, 4: period in frames of repeat pulses (`KEY_REPEAT_EN` only).

Ports:
- `frame_clk`  in  1  frame-rate clock.
- `Reset`  in  1  reset Reset, asynchronous, active-high; clock frame_clk.
- `report_valid`  in  1  one-cycle strobe, new report on `report_keys`.
- `report_keys`  in  8*NUM_SLOTS  slot i at [8i+7:8i]; 0x00 = empty.
- `keycode`  out  8  active key to the motion block; 0x00 = none.
- `key_new`  out  1  one-cycle pulse when the stack top changes to a nonzero code.
- `held_count`  out  $clog2(NUM_SLOTS+1)  number of held-stack entries.
- `timeout`  out  1  high while in forced-release state.

## Operation
- Reset (async): stack empty, candidate = 0, stability count = 0, frame counter = 0. All outputs 0.
- Filtering: codes 0x00–0x03 (empty/HID error) ignored. A code repeated within one report counts once.
- Debounce:
  - On `report_valid`, if the filtered report differs from the candidate: candidate <= report, count <= 1.
  - If it equals the candidate: count increments, saturating at `STABLE_REPORTS`.
  - Commit occurs on the report where count reaches `STABLE_REPORTS`, once per distinct candidate.
  - With `STABLE_REPORTS` = 1, every changed report commits immediately.
- Commit / stack update, in one cycle:
  - Remove entries absent from the new report, compacting toward the bottom and preserving order.
  - Push keys present in the report but not in the stack, in ascending slot order; the last one pushed is the top.
  - Stack full: excess new keys are dropped silently.
- Output without repeat: `keycode` = stack top, or 0x00 if the stack is empty.
- Timeout:
  - Frame counter resets on every `report_valid` and otherwise increments, saturating.
  - When it reaches `TIMEOUT_FRAMES`: stack cleared, candidate cleared, count = 0, `timeout` = 1.
  - `timeout` clears on the next `report_valid`, which is then processed normally.
- Simultaneous events: `report_valid` on the frame the counter would expire means the report wins and no timeout occurs.

## Timing
- `keycode`, `held_count` and `key_new` are registered and change on the same edge that samples the committing `report_valid`. Latency is 1 cycle.
- `key_new` is high for exactly one cycle per top change, including a fallback to an older held key. It is not raised when the top becomes 0x00.
- Reset asserted mid-operation clears state within the same cycle (async). The first commit after release needs `STABLE_REPORTS` reports.

## Configuration
- `KEY_REPEAT_EN` undefined: `keycode` follows the stack top continuously (level mode, continuous brush motion).
- `KEY_REPEAT_EN` defined: a step-mode gating FSM sits between stack top and `keycode`.
  - IDLE: `keycode` = 0.
  - PRESS: `keycode` = top for one frame, then DELAY.
  - DELAY: `keycode` = 0 for `REPEAT_DELAY` frames, then REPEAT.
  - REPEAT: `keycode` = top for one frame every `REPEAT_RATE` frames, 0 in between.
  - Any top change to nonzero goes to PRESS. Top = 0 goes to IDLE. Timeout goes to IDLE.

## Structure
- Shared package `paint_pkg`:
  - `typedef logic [7:0] keycode_t`
  - `KEY_NONE`=0x00, `KEY_W`=0x1A, `KEY_A`=0x04, `KEY_S`=0x16, `KEY_D`=0x07, `HID_ERR_MAX`=0x03
  - repeat-FSM state enum
- Sub-module `key_stack`: ordered NUM_SLOTS-entry stack with a combinational remove/compact/push step, exposing top and count. Debounce, timeout and repeat FSM stay in the top level.

## Test plan
- Reset, then two reports {0x1A} -> first report: `keycode`=0x00; second: `keycode`=0x1A, `key_new`=1 for one cycle, `held_count`=1.
- Stable {0x1A}, then two reports {0x1A,0x07} -> `keycode`=0x07. Then two reports {0x1A} -> `keycode`=0x1A with `key_new` pulse. Then two empty reports -> 0x00, no pulse.
- Alternating reports {0x04},{0x16},{0x04} -> no commit, `keycode` unchanged.
- Report {0x01,0x01,0x01,0x01} (phantom) -> ignored, stack empty.
- Held 0x16, no `report_valid` for 60 frames -> frame 60: `keycode`=0x00, `timeout`=1. Next report clears `timeout`. `report_valid` on frame 60 -> no timeout.
- `KEY_REPEAT_EN`, hold 0x07 -> 0x07 for 1 frame, 0x00 for 15 frames, then 0x07 on every 4th frame. Reset asserted mid-hold -> all outputs 0 immediately.
